// File: rtl/cacheline_adapter_pkg.sv
// Shared definitions for the cache-line to burst-memory adapter: default beat
// geometry, the fixed 256-bit line width and the controller state encoding.
package cacheline_adapter_pkg;

    localparam int DEFAULT_BEAT_W    = 64;
    localparam int DEFAULT_BURST_LEN = 4;
    localparam int LINE_W            = 256;
    // A 256-bit line is 32 bytes, so burst addresses drop the low 5 bits.
    localparam int LINE_OFFSET_W     = 5;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR,
        DONE
    } state_e;

endpackage

// File: rtl/cacheline_adapter.sv
// Cache-line adapter: converts one 256-bit line read/write from the cache side
// into a BURST_LEN-beat burst on the memory side.
// Optional build macro CACHELINE_ADAPTER_RADDR_CHECK_EN: when defined, a
// returning read beat is only counted if its address tag matches the burst
// address; when undefined every valid beat in RD_WAIT is taken and
// bmem_raddr is ignored.
module cacheline_adapter
    import cacheline_adapter_pkg::*;
#(
    parameter int BEAT_W    = DEFAULT_BEAT_W,
    parameter int BURST_LEN = DEFAULT_BURST_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       dfp_addr,
    input  logic              dfp_read,
    input  logic              dfp_write,
    input  logic [255:0]      dfp_wdata,
    output logic [255:0]      dfp_rdata,
    output logic              dfp_resp,
    output logic [31:0]       bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic              bmem_ready,
    input  logic [31:0]       bmem_raddr,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_rvalid
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    if (BEAT_W * BURST_LEN != LINE_W) begin : g_bad_geometry
        $error("cacheline_adapter: BEAT_W * BURST_LEN must equal the 256-bit line width");
    end

    state_e             state_q;
    state_e             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        addr_q;
    logic [LINE_W-1:0]  wdata_q;
    logic [LINE_W-1:0]  rdata_q;
    logic [31:0]        aligned_addr;
    logic               beat_take;

    assign aligned_addr = {dfp_addr[31:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};

`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
    assign beat_take = (state_q == RD_WAIT) && bmem_rvalid && (bmem_raddr == addr_q);

    logic unused_addr_bits;
    assign unused_addr_bits = ^dfp_addr[LINE_OFFSET_W-1:0];
`else
    assign beat_take = (state_q == RD_WAIT) && bmem_rvalid;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{dfp_addr[LINE_OFFSET_W-1:0], bmem_raddr};
`endif

    assign dfp_rdata = rdata_q;

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and memory/cache handshake outputs.
    always_comb begin
        state_d    = state_q;
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_addr  = '0;
        bmem_wdata = '0;
        dfp_resp   = 1'b0;
        case (state_q)
            IDLE: begin
                // A simultaneous read and write request resolves to the write.
                if (dfp_write) begin
                    state_d = WR;
                end else if (dfp_read) begin
                    state_d = RD_REQ;
                end
            end
            RD_REQ: begin
                bmem_read = 1'b1;
                bmem_addr = addr_q;
                if (bmem_ready) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (beat_take && (cnt_q == LAST_BEAT)) begin
                    state_d = DONE;
                end
            end
            WR: begin
                bmem_write = 1'b1;
                bmem_addr  = addr_q;
                bmem_wdata = wdata_q[cnt_q*BEAT_W +: BEAT_W];
                if (bmem_ready && (cnt_q == LAST_BEAT)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Leave unconditionally so the request still held this cycle
                // is not taken a second time.
                dfp_resp = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request latch, beat counter and read line assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (dfp_write) begin
                        addr_q  <= aligned_addr;
                        wdata_q <= dfp_wdata;
                    end else if (dfp_read) begin
                        addr_q <= aligned_addr;
                    end
                end
                RD_REQ: begin
                    if (bmem_ready) begin
                        cnt_q <= '0;
                    end
                end
                RD_WAIT: begin
                    if (beat_take) begin
                        rdata_q[cnt_q*BEAT_W +: BEAT_W] <= bmem_rdata;
                        cnt_q <= (cnt_q == LAST_BEAT) ? '0 : cnt_q + 1'b1;
                    end
                end
                WR: begin
                    if (bmem_ready) begin
                        cnt_q <= (cnt_q == LAST_BEAT) ? '0 : cnt_q + 1'b1;
                    end
                end
                default: begin
                    cnt_q <= cnt_q;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Testbench for cacheline_adapter: table of line transactions plus hand-written
// reset-abort sequence, with a scoreboard of expected write beats and responses.
module tb_cacheline_adapter;

    localparam int BW = 64;
    localparam int BL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   dfp_addr;
    logic          dfp_read;
    logic          dfp_write;
    logic [255:0]  dfp_wdata;
    logic [255:0]  dfp_rdata;
    logic          dfp_resp;
    logic [31:0]   bmem_addr;
    logic          bmem_read;
    logic          bmem_write;
    logic [BW-1:0] bmem_wdata;
    logic          bmem_ready;
    logic [31:0]   bmem_raddr;
    logic [BW-1:0] bmem_rdata;
    logic          bmem_rvalid;

    cacheline_adapter #(.BEAT_W(BW), .BURST_LEN(BL)) dut (
        .clk        (clk),
        .rst        (rst),
        .dfp_addr   (dfp_addr),
        .dfp_read   (dfp_read),
        .dfp_write  (dfp_write),
        .dfp_wdata  (dfp_wdata),
        .dfp_rdata  (dfp_rdata),
        .dfp_resp   (dfp_resp),
        .bmem_addr  (bmem_addr),
        .bmem_read  (bmem_read),
        .bmem_write (bmem_write),
        .bmem_wdata (bmem_wdata),
        .bmem_ready (bmem_ready),
        .bmem_raddr (bmem_raddr),
        .bmem_rdata (bmem_rdata),
        .bmem_rvalid(bmem_rvalid)
    );

    always #5 clk = ~clk;

    // kind: 0 read, 1 write, 2 read+write asserted together (write expected)
    typedef struct {
        int           kind;
        logic [31:0]  addr;
        logic [31:0]  exp_addr;
        logic [255:0] mem_line;
        logic [255:0] exp_line;
        int           stall_beat;
        int           stall_cyc;
        bit           bad_raddr;
    } vec_t;

    typedef struct {
        bit           is_read;
        logic [255:0] rdata;
    } resp_t;

    vec_t          vecs[8];
    resp_t         resp_q[$];
    logic [BW-1:0] wbeat_q[$];
    logic [31:0]   wr_addr_exp;
    int            rd_cycles;
    int            checks;
    int            failures;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: pops expected write beats and responses as the DUT produces them.
    always @(negedge clk) begin
        if (!rst) begin
            if (bmem_read) rd_cycles++;
            if (bmem_write && bmem_ready) begin
                if (wbeat_q.size() == 0) begin
                    check("wr_beat_unexpected", 256'(bmem_wdata), 256'(0));
                end else begin
                    logic [BW-1:0] eb;
                    eb = wbeat_q.pop_front();
                    check("wr_beat_data", 256'(bmem_wdata), 256'(eb));
                    check("wr_beat_addr", 256'(bmem_addr), 256'(wr_addr_exp));
                end
            end
            if (dfp_resp) begin
                if (resp_q.size() == 0) begin
                    check("resp_unexpected", 256'(dfp_resp), 256'(0));
                end else begin
                    resp_t er;
                    er = resp_q.pop_front();
                    if (er.is_read) check("rd_line", dfp_rdata, er.rdata);
                end
            end
        end
    end

    task automatic run_read(input vec_t v);
        resp_t r;
        r.is_read = 1'b1;
        r.rdata   = v.exp_line;
        resp_q.push_back(r);
        dfp_addr  = v.addr;
        dfp_read  = 1'b1;
        dfp_write = 1'b0;
        tick();
        for (int s = 0; s < v.stall_cyc; s++) begin
            bmem_ready  = 1'b0;
            bmem_rvalid = 1'b1;
            bmem_rdata  = 64'hBADB_ADBA_DBAD_BADB;
            bmem_raddr  = v.exp_addr;
            check("rd_req_stall_addr", 256'({bmem_read, bmem_addr}), 256'({1'b1, v.exp_addr}));
            tick();
        end
        bmem_ready  = 1'b1;
        bmem_rvalid = 1'b0;
        check("rd_req_addr", 256'({bmem_read, bmem_addr}), 256'({1'b1, v.exp_addr}));
        tick();
        check("rd_req_dropped", 256'(bmem_read), 256'(0));
        for (int i = 0; i < BL; i++) begin
`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
            if (v.bad_raddr && i == 2) begin
                bmem_rvalid = 1'b1;
                bmem_raddr  = v.exp_addr ^ 32'h0000_0040;
                bmem_rdata  = 64'hFEED_FACE_FEED_FACE;
                tick();
                check("rd_bad_tag_no_resp", 256'(dfp_resp), 256'(0));
            end
            bmem_raddr = v.exp_addr;
`else
            bmem_raddr = v.bad_raddr ? (v.exp_addr ^ 32'h0000_0040) : v.exp_addr;
`endif
            bmem_rvalid = 1'b1;
            bmem_rdata  = v.mem_line[i*BW +: BW];
            tick();
        end
        bmem_rvalid = 1'b0;
        check("rd_resp_latency", 256'(dfp_resp), 256'(1));
        tick();
        dfp_read = 1'b0;
        check("rd_no_reaccept", 256'({dfp_resp, bmem_read}), 256'(0));
        tick();
        check("rd_idle", 256'({dfp_resp, bmem_read, bmem_write}), 256'(0));
    endtask

    task automatic run_write(input vec_t v);
        resp_t r;
        int    cyc;
        int    accepted;
        int    stall_left;
        int    rd_before;
        r.is_read = 1'b0;
        r.rdata   = '0;
        resp_q.push_back(r);
        for (int i = 0; i < BL; i++) wbeat_q.push_back(v.exp_line[i*BW +: BW]);
        wr_addr_exp = v.exp_addr;
        rd_before   = rd_cycles;
        dfp_addr    = v.addr;
        dfp_wdata   = v.mem_line;
        dfp_write   = 1'b1;
        dfp_read    = (v.kind == 2);
        bmem_ready  = 1'b1;
        tick();
        cyc        = 1;
        accepted   = 0;
        stall_left = v.stall_cyc;
        while (!dfp_resp && cyc < 64) begin
            if (bmem_write && accepted == v.stall_beat && stall_left > 0) begin
                bmem_ready = 1'b0;
                stall_left--;
                check("wr_stall_hold", 256'({bmem_addr, bmem_wdata}),
                      256'({v.exp_addr, v.exp_line[accepted*BW +: BW]}));
            end else begin
                bmem_ready = 1'b1;
                if (bmem_write) accepted++;
            end
            tick();
            cyc++;
        end
        bmem_ready = 1'b1;
        check("wr_resp_latency", 256'(cyc), 256'(5 + v.stall_cyc));
        check("wr_beats_accepted", 256'(accepted), 256'(BL));
        tick();
        dfp_write = 1'b0;
        dfp_read  = 1'b0;
        check("wr_no_reaccept", 256'({dfp_resp, bmem_write, bmem_read}), 256'(0));
        tick();
        check("wr_idle", 256'({dfp_resp, bmem_write}), 256'(0));
        check("wr_no_bmem_read", 256'(rd_cycles), 256'(rd_before));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks      = 0;
        failures    = 0;
        rd_cycles   = 0;
        wr_addr_exp = '0;

        vecs[0] = '{0, 32'h1000_0024, 32'h1000_0020,
                    {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                    {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, -1, 0, 1'b0};
        vecs[1] = '{1, 32'h2000_0000, 32'h2000_0000,
                    {32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0},
                    {64'h0000_0007_0000_0006, 64'h0000_0005_0000_0004,
                     64'h0000_0003_0000_0002, 64'h0000_0001_0000_0000}, -1, 0, 1'b0};
        vecs[2] = '{1, 32'h2000_0040, 32'h2000_0040,
                    {64'hA3A3_A3A3_0000_0003, 64'hA2A2_A2A2_0000_0002,
                     64'hA1A1_A1A1_0000_0001, 64'hA0A0_A0A0_0000_0000},
                    {64'hA3A3_A3A3_0000_0003, 64'hA2A2_A2A2_0000_0002,
                     64'hA1A1_A1A1_0000_0001, 64'hA0A0_A0A0_0000_0000}, 2, 3, 1'b0};
        vecs[3] = '{0, 32'h3000_001F, 32'h3000_0000,
                    {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                     64'h0F0F_0F0F_F0F0_F0F0, 64'h5555_AAAA_5555_AAAA},
                    {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                     64'h0F0F_0F0F_F0F0_F0F0, 64'h5555_AAAA_5555_AAAA}, -1, 2, 1'b0};
        vecs[4] = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFE0,
                    {64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000,
                     64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFE},
                    {64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000,
                     64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFE}, 0, 1, 1'b0};
        vecs[5] = '{0, 32'h0000_0108, 32'h0000_0100,
                    {64'hC0DE_0000_0000_0004, 64'hC0DE_0000_0000_0003,
                     64'hC0DE_0000_0000_0002, 64'hC0DE_0000_0000_0001},
                    {64'hC0DE_0000_0000_0004, 64'hC0DE_0000_0000_0003,
                     64'hC0DE_0000_0000_0002, 64'hC0DE_0000_0000_0001}, -1, 0, 1'b1};
        vecs[6] = '{2, 32'h6000_0010, 32'h6000_0000,
                    {64'hBEEF_0000_0000_0033, 64'hBEEF_0000_0000_0022,
                     64'hBEEF_0000_0000_0011, 64'hBEEF_0000_0000_0000},
                    {64'hBEEF_0000_0000_0033, 64'hBEEF_0000_0000_0022,
                     64'hBEEF_0000_0000_0011, 64'hBEEF_0000_0000_0000}, -1, 0, 1'b0};
        vecs[7] = '{1, 32'h7000_0060, 32'h7000_0060,
                    {64'h1357_9BDF_0000_0003, 64'h2468_ACE0_0000_0002,
                     64'h1357_9BDF_0000_0001, 64'h2468_ACE0_0000_0000},
                    {64'h1357_9BDF_0000_0003, 64'h2468_ACE0_0000_0002,
                     64'h1357_9BDF_0000_0001, 64'h2468_ACE0_0000_0000}, 3, 2, 1'b0};

        rst         = 1'b1;
        dfp_addr    = '0;
        dfp_read    = 1'b0;
        dfp_write   = 1'b0;
        dfp_wdata   = '0;
        bmem_ready  = 1'b1;
        bmem_raddr  = '0;
        bmem_rdata  = '0;
        bmem_rvalid = 1'b0;
        tick();
        tick();
        check("rst_dfp_resp",   256'(dfp_resp),   256'(0));
        check("rst_bmem_read",  256'(bmem_read),  256'(0));
        check("rst_bmem_write", 256'(bmem_write), 256'(0));
        check("rst_bmem_addr",  256'(bmem_addr),  256'(0));
        check("rst_bmem_wdata", 256'(bmem_wdata), 256'(0));
        check("rst_dfp_rdata",  dfp_rdata,        256'(0));
        rst = 1'b0;
        tick();

        for (int n = 0; n < 8; n++) begin
            if (vecs[n].kind == 0) run_read(vecs[n]);
            else                   run_write(vecs[n]);
        end

        // Reset in the middle of a read burst: abort silently, drop late beats.
        dfp_addr  = 32'h4000_0000;
        dfp_read  = 1'b1;
        tick();
        check("abort_rd_req", 256'({bmem_read, bmem_addr}), 256'({1'b1, 32'h4000_0000}));
        tick();
        for (int i = 0; i < 2; i++) begin
            bmem_rvalid = 1'b1;
            bmem_raddr  = 32'h4000_0000;
            bmem_rdata  = 64'h9999_0000_0000_0000 | 64'(i);
            tick();
        end
        bmem_rvalid = 1'b0;
        dfp_read    = 1'b0;
        rst         = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_rdata_cleared", dfp_rdata, 256'(0));
        for (int i = 2; i < 4; i++) begin
            bmem_rvalid = 1'b1;
            bmem_raddr  = 32'h4000_0000;
            bmem_rdata  = 64'h9999_0000_0000_0000 | 64'(i);
            check("abort_no_activity", 256'({dfp_resp, bmem_read, bmem_write}), 256'(0));
            tick();
        end
        bmem_rvalid = 1'b0;
        tick();
        check("abort_no_resp", 256'({dfp_resp, bmem_read, bmem_write}), 256'(0));
        check("abort_rdata_still_zero", dfp_rdata, 256'(0));
        run_read(vecs[0]);

        tick();
        check("sb_resp_drained",  256'(resp_q.size()),  256'(0));
        check("sb_beats_drained", 256'(wbeat_q.size()), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
